// File: rtl/mem_bus_narrower.sv
// mem_bus_narrower: bridges a 32-bit load/store port onto a 16-bit memory bus,
// splitting words into two halfword beats and extending narrow loads.
module mem_bus_narrower #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_be,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t            state;
    logic              we_q, uns_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [15:0]       lo_q;
    logic              bad, beat;
    logic [7:0]        byte_sel;
    logic [31:0]       load_val;

    assign bad = (req_size == 2'b11) || (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                 (req_size == 2'b01 && req_addr[0]);
    assign req_ready = (state == IDLE);
    assign beat = (state == BEAT0) || (state == BEAT1);
    assign mem_valid = beat;
    assign mem_we = beat && we_q;
    // Accepted requests are already aligned, so only bit 1 needs forcing for the high word half.
    assign mem_addr = beat ? {addr_q[ADDR_W-1:2], (state == BEAT1) | addr_q[1], 1'b0} : '0;
    assign mem_be = !beat ? 2'b00 : (size_q == 2'b00) ? (addr_q[0] ? 2'b10 : 2'b01) : 2'b11;
    assign mem_wdata = !beat ? 16'h0 : (size_q == 2'b00) ? {2{wdata_q[7:0]}} :
                       (state == BEAT1) ? wdata_q[31:16] : wdata_q[15:0];
    assign byte_sel = addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
    assign load_val = we_q ? 32'h0 :
                      (size_q == 2'b10) ? {mem_rdata, lo_q} :
                      (size_q == 2'b01) ? {{16{~uns_q & mem_rdata[15]}}, mem_rdata} :
                                          {{24{~uns_q & byte_sel[7]}}, byte_sel};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            lo_q      <= 16'h0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    uns_q   <= req_unsigned;
                    size_q  <= req_size;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    if (bad) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'h0;
                    end else begin
                        state <= BEAT0;
                    end
                end
                BEAT0: if (mem_ready) begin
                    lo_q <= mem_rdata;
                    if (size_q == 2'b10) begin
                        state <= BEAT1;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= load_val;
                    end
                end
                BEAT1: if (mem_ready) begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= load_val;
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_narrower.sv
// tb_mem_bus_narrower: scoreboard bench with a byte-level memory reference model
// and a wait-state-injecting memory responder.
module tb_mem_bus_narrower;
    logic        clk = 0, rst_n = 0;
    logic        req_valid = 0, req_we = 0, req_unsigned = 0, mem_ready = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [15:0] mem_rdata = 0;
    logic        req_ready, rsp_valid, rsp_err, mem_valid, mem_we;
    logic [31:0] rsp_rdata, mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;

    always #5 clk = ~clk;

    mem_bus_narrower #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {logic [31:0] addr; logic we; logic [1:0] be; logic [15:0] wdata;} beat_t;
    typedef struct {logic [31:0] rdata; logic err;} rsp_t;

    beat_t      bq[$];
    rsp_t       rq[$];
    int         wq[$];
    logic [7:0] gold[2048];
    logic [7:0] bus[2048];
    int         checks = 0, errors = 0, rsp_seen = 0;
    bit         rand_w = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic poke(input int a, input logic [7:0] v);
        gold[a] = v;
        bus[a] = v;
    endtask

    // Reference model: operates on bytes of the golden memory, then describes the bus beats.
    task automatic model(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                         input logic [31:0] wd);
        int ai, nb;
        logic [31:0] v;
        beat_t b;
        ai = int'(a);
        nb = 1 << sz;
        if (sz == 2'd3 || ai % nb != 0) begin
            rq.push_back('{32'h0, 1'b1});
            return;
        end
        v = 0;
        for (int i = 0; i < nb; i++)
            if (we) gold[ai+i] = wd[8*i+:8];
            else v[8*i+:8] = gold[ai+i];
        if (!we && !uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 1);
        rq.push_back('{v, 1'b0});
        for (int h = ai & ~1; h < ai + nb; h += 2) begin
            b.addr = 32'(h);
            b.we = we;
            b.be = {h + 1 >= ai && h + 1 < ai + nb, h >= ai && h < ai + nb};
            b.wdata = nb == 1 ? {2{wd[7:0]}} : wd[8*(h-ai)+:16];
            bq.push_back(b);
        end
    endtask

    task automatic accept(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                          input logic [31:0] wd);
        int n;
        @(negedge clk);
        for (n = 0; n < 20 && !req_ready; n++) @(negedge clk);
        if (!req_ready) chk("req_ready_timeout", {31'h0, req_ready}, 32'h1);
        req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 0;
    endtask

    task automatic op(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                      input logic [31:0] wd, output int lat, output logic [31:0] rd);
        int n;
        model(we, sz, uns, a, wd);
        accept(we, sz, uns, a, wd);
        for (n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        lat = n;
        rd = rsp_rdata;
        if (n > 60) chk("rsp_timeout", 32'(n), 32'd60);
    endtask

    rsp_t mon_r;
    initial forever begin
        @(negedge clk);
        if (rsp_valid) begin
            rsp_seen++;
            if (rq.size() == 0) chk("unexpected_rsp", {31'h0, rsp_valid}, 32'h0);
            else begin
                mon_r = rq.pop_front();
                chk("rsp_rdata", rsp_rdata, mon_r.rdata);
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, mon_r.err});
            end
        end
    end

    int    scnt = 0, stgt = 0;
    bit    armed = 0;
    beat_t snap, e;
    initial forever begin
        @(negedge clk);
        mem_ready = 0;
        if (!rst_n) begin
            scnt = 0;
            armed = 0;
        end else if (mem_valid) begin
            if (!armed) begin
                stgt = wq.size() != 0 ? wq.pop_front() : rand_w ? int'($urandom_range(0, 3)) : 0;
                armed = 1;
                scnt = 0;
            end
            if (scnt == 0) snap = '{mem_addr, mem_we, mem_be, mem_wdata};
            else begin
                chk("stall_addr", mem_addr, snap.addr);
                chk("stall_we", {31'h0, mem_we}, {31'h0, snap.we});
                chk("stall_be", {30'h0, mem_be}, {30'h0, snap.be});
                chk("stall_wdata", {16'h0, mem_wdata}, {16'h0, snap.wdata});
            end
            if (scnt < stgt) scnt++;
            else begin
                mem_ready = 1;
                mem_rdata = {bus[mem_addr[10:0]+11'd1], bus[mem_addr[10:0]]};
                armed = 0;
                if (bq.size() == 0) chk("unexpected_beat", {31'h0, mem_valid}, 32'h0);
                else begin
                    e = bq.pop_front();
                    chk("beat_addr", mem_addr, e.addr);
                    chk("beat_we", {31'h0, mem_we}, {31'h0, e.we});
                    chk("beat_be", {30'h0, mem_be}, {30'h0, e.be});
                    if (e.we) chk("beat_wdata", {16'h0, mem_wdata}, {16'h0, e.wdata});
                end
                if (mem_we && mem_be[0]) bus[mem_addr[10:0]] = mem_wdata[7:0];
                if (mem_we && mem_be[1]) bus[mem_addr[10:0]+11'd1] = mem_wdata[15:8];
            end
        end
    end

    task automatic chk_idle_outputs(input string n);
        chk({n, "_req_ready"}, {31'h0, req_ready}, 32'h1);
        chk({n, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
        chk({n, "_rsp_rdata"}, rsp_rdata, 32'h0);
        chk({n, "_rsp_err"}, {31'h0, rsp_err}, 32'h0);
        chk({n, "_mem_valid"}, {31'h0, mem_valid}, 32'h0);
        chk({n, "_mem_bus"}, {13'h0, mem_we, mem_be, mem_wdata}, 32'h0);
        chk({n, "_mem_addr"}, mem_addr, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int          lat, seen0;
    logic [31:0] rd;
    initial begin
        for (int i = 0; i < 2048; i++) gold[i] = 8'($urandom);
        bus = gold;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1;

        op(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, lat, rd);
        chk("sw_latency", 32'(lat), 32'd3);
        chk("sw_rdata", rd, 32'h0);

        poke(32'h200, 8'h78); poke(32'h201, 8'h56); poke(32'h202, 8'h34); poke(32'h203, 8'h12);
        wq = '{2, 0};
        op(0, 2'd2, 0, 32'h200, 32'h0, lat, rd);
        chk("lw_latency", 32'(lat), 32'd5);
        chk("lw_rdata", rd, 32'h12345678);

        poke(32'h300, 8'hFF); poke(32'h301, 8'h80);
        op(0, 2'd0, 0, 32'h301, 32'h0, lat, rd);
        chk("lb_latency", 32'(lat), 32'd2);
        chk("lb_301", rd, 32'hFFFFFF80);
        op(0, 2'd0, 1, 32'h301, 32'h0, lat, rd);
        chk("lbu_301", rd, 32'h00000080);
        op(0, 2'd0, 0, 32'h300, 32'h0, lat, rd);
        chk("lb_300", rd, 32'hFFFFFFFF);

        op(1, 2'd0, 0, 32'h401, 32'h000000A5, lat, rd);
        chk("sb_latency", 32'(lat), 32'd2);
        op(1, 2'd1, 0, 32'h402, 32'h00001234, lat, rd);
        chk("sh_latency", 32'(lat), 32'd2);
        op(0, 2'd1, 0, 32'h402, 32'h0, lat, rd);
        chk("lh_402", rd, 32'h00001234);

        op(0, 2'd2, 0, 32'h102, 32'h0, lat, rd);
        chk("err_lw_latency", 32'(lat), 32'd1);
        chk("err_lw_rdata", rd, 32'h0);
        op(0, 2'd1, 0, 32'h101, 32'h0, lat, rd);
        chk("err_lh_latency", 32'(lat), 32'd1);
        op(1, 2'd3, 0, 32'h100, 32'hFFFFFFFF, lat, rd);
        chk("err_size_latency", 32'(lat), 32'd1);

        rand_w = 1;
        for (int i = 0; i < 300; i++)
            op(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
               32'($urandom_range(0, 2040)), $urandom, lat, rd);

        // Stall the high beat of a word store, then pull reset underneath it.
        rand_w = 0;
        wq = '{0, 10};
        model(1, 2'd2, 0, 32'h500, 32'hCAFEF00D);
        accept(1, 2'd2, 0, 32'h500, 32'hCAFEF00D);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_valid && mem_addr == 32'h502) break;
        end
        chk("rst_in_beat1", mem_addr, 32'h502);
        seen0 = rsp_seen;
        #2 rst_n = 0;
        #1 chk_idle_outputs("async_rst");
        rq.delete(); bq.delete(); wq.delete();
        gold = bus;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (6) @(negedge clk);
        chk("rst_no_rsp", 32'(rsp_seen), 32'(seen0));
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);

        op(1, 2'd2, 0, 32'h600, 32'h89ABCDEF, lat, rd);
        op(0, 2'd1, 0, 32'h602, 32'h0, lat, rd);
        chk("post_rst_lh", rd, 32'hFFFF89AB);

        repeat (4) @(negedge clk);
        chk("rsp_queue_empty", 32'(rq.size()), 32'd0);
        chk("beat_queue_empty", 32'(bq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
